// File: rtl/bsg_ssi_downstream_in.sv
// Receive side of a source-synchronous link channel: assembles DDR beats into words,
// buffers them for the core and returns credit tokens. Optional stats: BSG_SSI_DOWNSTREAM_STATS_EN.
//
// state    | meaning
// IDLE     | no partial word held; next valid beat goes to slot 0
// ASSEMBLE | beats 0..beat_cnt-1 captured; waiting for the rest of the word
module bsg_ssi_downstream_in #(
  parameter int CHANNEL_WIDTH  = 8,
  parameter int BEATS_PER_WORD = 2,
  parameter int FIFO_ELS       = 16,
  parameter int TOKEN_RATIO    = 4,
  localparam int WORD_WIDTH    = 2*CHANNEL_WIDTH*BEATS_PER_WORD
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       io_valid_i,
  input  logic [2*CHANNEL_WIDTH-1:0] io_data_i,
  output logic                       io_token_o,
  output logic                       valid_o,
  output logic [WORD_WIDTH-1:0]      data_o,
  input  logic                       yumi_i,
`ifdef BSG_SSI_DOWNSTREAM_STATS_EN
  output logic [15:0]                words_rx_o,
  output logic [15:0]                words_drop_o,
`endif
  output logic                       overflow_o
);

  localparam int BEAT_W = 2*CHANNEL_WIDTH;
  localparam int CNT_W  = (BEATS_PER_WORD > 1) ? $clog2(BEATS_PER_WORD) : 1;
  localparam int PTR_W  = $clog2(FIFO_ELS);
  localparam int TOK_W  = (TOKEN_RATIO > 1) ? $clog2(TOKEN_RATIO) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS_PER_WORD-1);
  localparam logic [TOK_W-1:0] LAST_TOK  = TOK_W'(TOKEN_RATIO-1);

  typedef enum logic {IDLE, ASSEMBLE} state_e;

  state_e                 state_q, state_n;
  logic [CNT_W-1:0]       beat_cnt_q, beat_cnt_n;
  logic                   word_done;
  logic [WORD_WIDTH-1:0]  asm_q;
  logic [WORD_WIDTH-1:0]  wr_word;

  logic [WORD_WIDTH-1:0]  mem_q [FIFO_ELS];
  logic [PTR_W:0]         wr_ptr_q, rd_ptr_q;
  logic [PTR_W-1:0]       wr_idx, rd_idx;
  logic                   full, empty, enq, deq, drop;

  logic [TOK_W-1:0]       tok_cnt_q;
  logic                   token_q;
  logic                   overflow_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_n;
      beat_cnt_q <= beat_cnt_n;
    end
  end

  always_comb begin
    state_n    = state_q;
    beat_cnt_n = beat_cnt_q;
    word_done  = 1'b0;
    case (state_q)
      IDLE: begin
        if (io_valid_i) begin
          if (BEATS_PER_WORD == 1) begin
            word_done = 1'b1;
          end else begin
            state_n    = ASSEMBLE;
            beat_cnt_n = CNT_W'(1);
          end
        end
      end
      ASSEMBLE: begin
        if (io_valid_i) begin
          if (beat_cnt_q == LAST_BEAT) begin
            word_done  = 1'b1;
            state_n    = IDLE;
            beat_cnt_n = '0;
          end else begin
            beat_cnt_n = beat_cnt_q + CNT_W'(1);
          end
        end
      end
      default: begin
        state_n    = IDLE;
        beat_cnt_n = '0;
      end
    endcase
  end

  // The completing word merges the live beat into the held partial word.
  always_comb begin
    wr_word = asm_q;
    wr_word[int'(beat_cnt_q)*BEAT_W +: BEAT_W] = io_data_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      asm_q <= '0;
    end else if (io_valid_i) begin
      asm_q <= wr_word;
    end
  end

  assign wr_idx = wr_ptr_q[PTR_W-1:0];
  assign rd_idx = rd_ptr_q[PTR_W-1:0];
  assign empty  = (wr_ptr_q == rd_ptr_q);
  assign full   = (wr_idx == rd_idx) && (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]);
  assign deq    = yumi_i && !empty;
  // A pop in the same cycle frees the slot the completing word needs.
  assign enq    = word_done && (!full || deq);
  assign drop   = word_done && full && !deq;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < FIFO_ELS; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (enq) begin
        mem_q[wr_idx] <= wr_word;
        wr_ptr_q      <= wr_ptr_q + 1'b1;
      end
      if (deq) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
    end
  end

  assign valid_o = !empty;
  assign data_o  = mem_q[rd_idx];

  always_ff @(posedge clk) begin
    if (rst) begin
      tok_cnt_q <= '0;
      token_q   <= 1'b0;
    end else if (deq) begin
      if (tok_cnt_q == LAST_TOK) begin
        tok_cnt_q <= '0;
        token_q   <= ~token_q;
      end else begin
        tok_cnt_q <= tok_cnt_q + TOK_W'(1);
      end
    end
  end

  assign io_token_o = token_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_q <= 1'b0;
    end else if (drop) begin
      overflow_q <= 1'b1;
    end
  end

  assign overflow_o = overflow_q;

`ifdef BSG_SSI_DOWNSTREAM_STATS_EN
  logic [15:0] rx_cnt_q, drop_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_cnt_q   <= '0;
      drop_cnt_q <= '0;
    end else begin
      if (enq)  rx_cnt_q   <= rx_cnt_q + 16'd1;
      if (drop) drop_cnt_q <= drop_cnt_q + 16'd1;
    end
  end

  assign words_rx_o   = rx_cnt_q;
  assign words_drop_o = drop_cnt_q;
`endif

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(yumi_i && !valid_o));
    end
  end
`endif

endmodule

// File: doc/bsg_ssi_downstream_in.md
Name: bsg_ssi_downstream_in

Overview:
- Receive side of the source-synchronous off-chip link; the far end of the upstream output channel.
- Takes per-cycle DDR beats (positive- and negative-phase bytes, already captured into the io clock domain) and assembles them into core words.
- Buffers words in a credit-sized FIFO for the core and returns tokens to the transmitter so its credit counters advance.
- One instance per physical channel; sits between the input PHY capture flops and the core-side channel combiner.

Parameters:
- CHANNEL_WIDTH, 8, bits per DDR phase.
- BEATS_PER_WORD, 2, io beats (pos+neg pairs) per assembled word; minimum 1.
- FIFO_ELS, 16, word buffer depth; power of two; equals the transmitter's initial credit count.
- TOKEN_RATIO, 4, words dequeued per token edge; must divide FIFO_ELS.
- Derived: WORD_WIDTH = 2*CHANNEL_WIDTH*BEATS_PER_WORD (default 32).

Ports:
- clk  in  1  io clock; all state on posedge.
- rst  in  1  synchronous, active-high reset.
- io_valid_i  in  1  beat valid this cycle.
- io_data_i  in  2*CHANNEL_WIDTH  beat data; [CHANNEL_WIDTH-1:0] is the pos phase, upper half is the neg phase.
- io_token_o  out  1  token line; toggles once per TOKEN_RATIO dequeued words.
- valid_o  out  1  head word available.
- data_o  out  WORD_WIDTH  head word.
- yumi_i  in  1  core consumes head word this cycle; legal only when valid_o=1.
- overflow_o  out  1  sticky: a completed word arrived with the FIFO full.

Behaviour:
- Clocking and reset: one clock (clk); synchronous active-high reset (rst).
- Reset values: valid_o=0, io_token_o=0, overflow_o=0, data_o=0. The FIFO is emptied, the beat counter and token counter clear, and the FSM goes to IDLE.
- Reset mid-word: the partial word is discarded. Words already in the FIFO are discarded.
- FSM states:
  - IDLE: beat_cnt=0. On io_valid_i, store the beat in slot 0. If BEATS_PER_WORD=1 the word completes; otherwise go to ASSEMBLE.
  - ASSEMBLE: on each io_valid_i, store the beat in slot beat_cnt and increment. When the last beat (index BEATS_PER_WORD-1) is stored, the word completes and the FSM returns to IDLE.
  - Cycles with io_valid_i=0 hold state; there is no timeout.
- Word packing: beat k occupies bits [(k+1)*2*CHANNEL_WIDTH-1 : k*2*CHANNEL_WIDTH], so beat 0 is in the LSBs.
- Enqueue: the completed word is written at the edge ending the last-beat cycle. valid_o rises the next cycle, so latency is 1 cycle from the last beat to valid_o.
- FIFO:
  - Read and write pointers with an extra wrap bit. Full when the indices are equal and the wrap bits differ; empty when fully equal.
  - data_o shows the head entry combinationally from the storage; it holds its value when empty.
- Dequeue: yumi_i with valid_o=1 pops at the edge. yumi_i with valid_o=0 is ignored and fires a simulation assertion.
- Full plus completion:
  - Full with a word completing and no yumi: the word is dropped, overflow_o is set and stays set until rst, and the FIFO contents are unchanged.
  - Full with a word completing and yumi_i in the same cycle: the write is accepted and the count is unchanged.
- Empty: a completing word bypasses nothing; it is always written first, so valid_o lags by 1 cycle.
- Token return:
  - Each accepted dequeue increments tok_cnt (0..TOKEN_RATIO-1).
  - When a dequeue occurs with tok_cnt=TOKEN_RATIO-1, tok_cnt wraps to 0 and io_token_o toggles at the same edge. io_token_o is registered.
  - Tokens depend only on dequeues, never on enqueues.
- Credit contract: a compliant transmitter never completes a word while the FIFO is full, so overflow_o=1 indicates a link fault.

Optional Feature:
- Macro: BSG_SSI_DOWNSTREAM_STATS_EN.
- Enabled:
  - Adds output words_rx_o [15:0]: count of accepted enqueues.
  - Adds output words_drop_o [15:0]: count of overflow drops.
  - Both clear on rst, wrap modulo 2^16, and update at the same edge as the event.
- Disabled: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Basic assembly: after rst, send beats 0x2211 then 0x4433 on consecutive cycles -> valid_o=1 one cycle after the 2nd beat; data_o=0x44332211; io_token_o=0.
- Gapped beats: beat 0x2211, 3 idle cycles, beat 0x4433 -> same word; valid_o only after the 2nd beat.
- Token return: fill 8 words, then pulse yumi_i 8 times -> io_token_o toggles after the 4th and 8th dequeue (0->1->0); tok_cnt=0 at the end.
- Overflow: fill 16 words with yumi_i=0, then complete a 17th -> overflow_o=1; the FIFO still holds words 1..16 in order. Repeat with yumi_i=1 in the 17th word's completion cycle -> no overflow, the 17th word appears last.
- Reset mid-word: send one beat, assert rst, then send 0xBBAA and 0xDDCC -> first word out is 0xDDCCBBAA; the stale beat never appears.
- Pointer wrap: stream 40 words with yumi_i tied to valid_o -> all 40 data match in order; io_token_o has toggled 10 times; overflow_o=0. With BSG_SSI_DOWNSTREAM_STATS_EN: words_rx_o=40, words_drop_o=0.
